// File: rtl/jesd_sysref_pkg.sv
// jesd_sysref_pkg: shared mode/state types for the SYSREF/LMFC controller
package jesd_sysref_pkg;

    typedef enum logic [1:0] {
        DISABLED   = 2'd0,
        ONESHOT    = 2'd1,
        CONTINUOUS = 2'd2,
        RSVD       = 2'd3
    } sysref_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ALIGNED = 2'd2
    } lmfc_state_e;

    function automatic logic mode_active(input sysref_mode_e m);
        return (m == ONESHOT) || (m == CONTINUOUS);
    endfunction

endpackage

// File: rtl/sysref_lmfc_ctrl_lmfc_counter.sv
// lmfc_counter: free-running LMFC phase counter with synchronous load and
// a registered pulse that marks phase zero.
module lmfc_counter #(
    parameter int LMFC_PERIOD = 8,
    parameter int CNT_W       = $clog2(LMFC_PERIOD)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             pulse_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q;

    always_comb begin
        cnt_d = load_i ? load_val_i
              : (cnt_q == CNT_W'(LMFC_PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
    end

    // Pulse follows the registered count, so a load to zero also pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= (cnt_d == '0);
        end
    end

    assign cnt_o   = cnt_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/sysref_lmfc_ctrl.sv
// sysref_lmfc_ctrl: aligns the LMFC counter to SYSREF edges and tracks
// phase consistency of later edges with sticky error reporting.
module sysref_lmfc_ctrl
    import jesd_sysref_pkg::*;
#(
    parameter int LMFC_PERIOD   = 8,
    parameter int SYSREF_OFFSET = 0,
    parameter int CNT_W         = $clog2(LMFC_PERIOD),
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sysref_i,
    input  logic [1:0]           mode_i,
    input  logic                 arm_i,
    input  logic                 realign_en_i,
    input  logic                 err_clr_i,
    output logic [CNT_W-1:0]     lmfc_cnt_o,
    output logic                 lmfc_pulse_o,
    output logic                 aligned_o,
    output logic                 armed_o,
    output logic                 sysref_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    sysref_mode_e         mode;
    lmfc_state_e          state_q, state_d;
    logic                 sysref_q, sysref_edge, mismatch, load, err_set;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     nxt_cnt;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d, err_base;

    assign mode        = sysref_mode_e'(mode_i);
    assign sysref_edge = sysref_i & ~sysref_q;
    // Phase the counter would reach next cycle if left alone.
    assign nxt_cnt  = (lmfc_cnt_o == CNT_W'(LMFC_PERIOD - 1)) ? '0 : lmfc_cnt_o + CNT_W'(1);
    assign mismatch = nxt_cnt != CNT_W'(SYSREF_OFFSET);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: if (arm_i) state_d = ARMED;
            ARMED: if (sysref_edge) begin
                load    = 1'b1;
                state_d = ALIGNED;
            end
            ALIGNED: if (arm_i) state_d = ARMED;
                else if (sysref_edge && mode == CONTINUOUS && mismatch) begin
                    err_set = 1'b1;
                    load    = realign_en_i;
                end
            default: state_d = IDLE;
        endcase
        if (!mode_active(mode)) state_d = IDLE;
    end

    // A new mismatch wins over a clear in the same cycle, counting from zero.
    always_comb begin
        err_base  = err_clr_i ? '0 : err_cnt_q;
        err_d     = err_set | (err_q & ~err_clr_i);
        err_cnt_d = (err_set && !(&err_base)) ? err_base + ERR_CNT_W'(1) : err_base;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sysref_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sysref_q  <= sysref_i;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    lmfc_counter #(
        .LMFC_PERIOD(LMFC_PERIOD),
        .CNT_W      (CNT_W)
    ) u_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (load),
        .load_val_i(CNT_W'(SYSREF_OFFSET)),
        .cnt_o     (lmfc_cnt_o),
        .pulse_o   (lmfc_pulse_o)
    );

    assign aligned_o    = state_q == ALIGNED;
    assign armed_o      = state_q == ARMED;
    assign sysref_err_o = err_q;
    assign err_cnt_o    = err_cnt_q;

endmodule
